instr_fetch_dispatch: RTL and testbench
=======================================

Name: instr_fetch_dispatch

Overview:
- Upstream stage of the per-opcode execution FSMs (MOVI, ADD, etc.).
- Fetches a 16-bit instruction word and holds it as the shared instruction register driven to every execution FSM.
- Waits for the execution FSM's done, then inserts a one-cycle NOP bubble so all execution FSMs return to their idle state before the next instruction is presented.
- Also handles NOP and HALT opcodes locally, counts retired instructions, and flags execution timeouts.

Parameters:
- IW, 16, instruction width.
- TIMEOUT, 32, maximum EXEC cycles to wait for done_in before aborting (range 2..255).
- HALT_OP, 4'b1111, opcode that stops the dispatcher.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0); one clock domain.
- run  input  1  level; start/continue fetching when high.
- mem_data  input  IW  instruction word from program memory.
- mem_valid  input  1  mem_data valid this cycle.
- mem_req  output  1  instruction fetch request.
- fullBitNum  output  IW  instruction presented to execution FSMs.
- done_in  input  1  OR of all execution FSM done outputs.
- pc_inc_nop  output  1  one-cycle PC increment for locally handled NOP.
- instr_count  output  16  retired-instruction counter.
- timeout_err  output  1  sticky; set on EXEC timeout.
- halted  output  1  high in HALT state.
- step  input  1  single-step pulse; used only with SINGLE_STEP_EN.

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, fullBitNum=0, mem_req=0, pc_inc_nop=0, instr_count=0, timeout_err=0, halted=0.
  - Timeout counter = 0; internal IR = 0.
- All outputs are registered.
- State IDLE:
  - fullBitNum=0.
  - run=1 → FETCH next cycle.
- State FETCH:
  - mem_req=1.
  - Waits any number of cycles for mem_valid.
  - On mem_valid=1: latch mem_data into IR, mem_req=0 next cycle.
  - Next state by opcode IR[15:12]:
    - 0000 → NOPX.
    - HALT_OP → HALT.
    - Otherwise → EXEC.
  - run=0 while in FETCH: finish the pending fetch, then go to IDLE instead of dispatching; IR is discarded and instr_count is not incremented.
- State EXEC:
  - fullBitNum=IR, held stable for the whole state.
  - Timeout counter increments every cycle.
  - done_in=1 on the first cycle seen → BUBBLE; instr_count += 1.
  - Counter reaches TIMEOUT-1 with no done_in → set timeout_err, go to BUBBLE, no count increment.
  - done_in and timeout in the same cycle: done wins, no error.
- State NOPX:
  - pc_inc_nop=1 for exactly one cycle; instr_count += 1 → BUBBLE.
- State BUBBLE:
  - fullBitNum=16'h0000 for exactly one cycle; timeout counter cleared.
  - Next: FETCH if run=1, else IDLE.
- State HALT:
  - fullBitNum=0, halted=1.
  - HALT is counted: instr_count += 1 on entry.
  - Stays in HALT until rst asserts; run is ignored.
- done_in outside EXEC is ignored.
- instr_count wraps 16'hFFFF → 16'h0000 silently.
- timeout_err stays set until reset.
- Reset mid-EXEC: immediate return to IDLE with fullBitNum=0, so downstream FSMs see opcode 0000 and reset their state.
- Latency from mem_valid to fullBitNum=instruction: 1 cycle.
- Minimum instruction period: FETCH(1) + EXEC(n) + BUBBLE(1).

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - In BUBBLE, after the one bubble cycle, the FSM waits in BUBBLE with fullBitNum=0 until a rising edge of step is detected (registered edge detect), then goes to FETCH.
  - run=0 still routes to IDLE.
- Undefined:
  - step is ignored and BUBBLE lasts exactly one cycle.

Test Plan:
- Reset, run=1, mem_data=16'h7083 with mem_valid=1 → fullBitNum=16'h7083 one cycle later; done_in=1 at EXEC cycle 2 → next cycle fullBitNum=16'h0000 for exactly 1 cycle, instr_count=1, mem_req=1 again.
- Fetch 16'h0000 → pc_inc_nop high exactly 1 cycle, fullBitNum never leaves 0, instr_count=1.
- Fetch 16'h1234, hold done_in=0 → timeout_err=1 after TIMEOUT=32 EXEC cycles, BUBBLE follows, instr_count unchanged.
- Fetch 16'hF000 → halted=1, fullBitNum=0, mem_req stays 0 for 50 cycles despite run=1; rst pulse low → halted=0.
- Assert rst low during EXEC of 16'h7083 → all outputs at reset values immediately (asynchronous), not waiting for a clock edge; instr_count=0.
- SINGLE_STEP_EN defined: two instructions issued, second fetch (mem_req) only after a step pulse; without step, bench holds BUBBLE ≥20 cycles.

Source files
------------

// File: rtl/instr_fetch_dispatch_if.sv
// Bundle between the fetch/dispatch stage and its environment.
// master = dispatcher side, slave = program memory / execution FSMs / control.
interface instr_fetch_dispatch_if #(
    parameter int unsigned IW = 16
);
    logic          run;
    logic          step;
    logic [IW-1:0] mem_data;
    logic          mem_valid;
    logic          mem_req;
    logic [IW-1:0] fullBitNum;
    logic          done_in;
    logic          pc_inc_nop;
    logic [15:0]   instr_count;
    logic          timeout_err;
    logic          halted;

    modport master (
        input  run, step, mem_data, mem_valid, done_in,
        output mem_req, fullBitNum, pc_inc_nop, instr_count, timeout_err, halted
    );

    modport slave (
        output run, step, mem_data, mem_valid, done_in,
        input  mem_req, fullBitNum, pc_inc_nop, instr_count, timeout_err, halted
    );
endinterface

// File: rtl/instr_fetch_dispatch.sv
// Instruction fetch/dispatch stage feeding the per-opcode execution FSMs.
// Optional SINGLE_STEP_EN: after each bubble, wait for a rising edge of step before fetching.
module instr_fetch_dispatch #(
    parameter int unsigned IW      = 16,
    parameter int unsigned TIMEOUT = 32,
    parameter logic [3:0]  HALT_OP = 4'b1111
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_dispatch_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_NOPX,
        ST_BUBBLE,
        ST_HALT,
        ST_STEP
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [IW-1:0] fbn_q, fbn_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          nop_q, nop_d;
    logic          terr_q, terr_d;
    logic          halt_q, halt_d;
    logic [3:0]    opcode;

    assign opcode = bus.mem_data[IW-1 -: 4];

`ifdef SINGLE_STEP_EN
    logic step_q;
    logic step_rise;

    assign step_rise = bus.step & ~step_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= bus.step;
        end
    end
`else
    logic step_unused;

    assign step_unused = bus.step;
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // A fetch already requested is always completed; run=0 only drops its result.
                if (bus.mem_valid) begin
                    if (!bus.run) begin
                        state_d = ST_IDLE;
                        ir_d    = '0;
                    end else begin
                        ir_d = bus.mem_data;
                        if (opcode == 4'b0000) begin
                            state_d = ST_NOPX;
                            cnt_d   = cnt_q + 16'd1;
                        end else if (opcode == HALT_OP) begin
                            state_d = ST_HALT;
                            cnt_d   = cnt_q + 16'd1;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                end
            end

            ST_EXEC: begin
                tmo_d = tmo_q + 8'd1;
                if (bus.done_in) begin
                    state_d = ST_BUBBLE;
                    cnt_d   = cnt_q + 16'd1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_BUBBLE;
                    terr_d  = 1'b1;
                end
            end

            ST_NOPX: begin
                state_d = ST_BUBBLE;
            end

            ST_BUBBLE: begin
                tmo_d = '0;
`ifdef SINGLE_STEP_EN
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else if (step_rise) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_STEP;
                end
`else
                state_d = bus.run ? ST_FETCH : ST_IDLE;
`endif
            end

`ifdef SINGLE_STEP_EN
            ST_STEP: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else if (step_rise) begin
                    state_d = ST_FETCH;
                end
            end
`endif

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so each one is aligned with the state it describes.
    always_comb begin
        mem_req_d = (state_d == ST_FETCH);
        nop_d     = (state_d == ST_NOPX);
        halt_d    = (state_d == ST_HALT);
        fbn_d     = (state_d == ST_EXEC) ? ir_d : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            fbn_q     <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            nop_q     <= 1'b0;
            terr_q    <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            fbn_q     <= fbn_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            mem_req_q <= mem_req_d;
            nop_q     <= nop_d;
            terr_q    <= terr_d;
            halt_q    <= halt_d;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.fullBitNum  = fbn_q;
    assign bus.pc_inc_nop  = nop_q;
    assign bus.instr_count = cnt_q;
    assign bus.timeout_err = terr_q;
    assign bus.halted      = halt_q;

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Bench for instr_fetch_dispatch: directed + randomized instructions against a per-instruction outcome model.
module tb_instr_fetch_dispatch;

    localparam int         TIMEOUT = 32;
    localparam logic [3:0] HALT_OP = 4'b1111;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_dispatch_if #(.IW(16)) bus ();

    instr_fetch_dispatch #(
        .IW(16),
        .TIMEOUT(TIMEOUT),
        .HALT_OP(HALT_OP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_count;
    logic [15:0] exp_terr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ir"},      bus.fullBitNum, 16'h0000);
        chk({tag, "_req"},     16'(bus.mem_req), 16'h0);
        chk({tag, "_nop"},     16'(bus.pc_inc_nop), 16'h0);
        chk({tag, "_count"},   bus.instr_count, 16'h0000);
        chk({tag, "_timeout"}, 16'(bus.timeout_err), 16'h0);
        chk({tag, "_halted"},  16'(bus.halted), 16'h0);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("fetch_request", 16'(bus.mem_req), 16'h1);
    endtask

    // After the single bubble cycle: next fetch is requested (after a step pulse in single-step builds).
    task automatic expect_refetch();
        int bad = 0;
        tick();
`ifdef SINGLE_STEP_EN
        chk("step_wait_req", 16'(bus.mem_req), 16'h0);
        repeat (20) begin
            tick();
            if (bus.mem_req !== 1'b0 || bus.fullBitNum !== 16'h0000) bad++;
        end
        chk("step_hold", 16'(bad), 16'h0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
`endif
        chk("refetch_req", 16'(bus.mem_req), 16'h1);
        chk("fetch_ir_zero", bus.fullBitNum, 16'h0000);
    endtask

    // Model: an instruction retires after min(done_delay, TIMEOUT) EXEC cycles; done_delay > TIMEOUT is a timeout.
    task automatic run_instr(input logic [15:0] word, input int done_delay, input int vdelay);
        logic [3:0] op;
        int         len;
        bit         retire;
        int         bad;
        op  = word[15:12];
        bad = 0;
        wait_req(200);
        repeat (vdelay) begin
            bus.done_in = 1'($urandom_range(0, 1));
            tick();
            if (bus.mem_req !== 1'b1 || bus.fullBitNum !== 16'h0000) bad++;
        end
        chk("fetch_wait", 16'(bad), 16'h0);
        bus.mem_data  = word;
        bus.mem_valid = 1'b1;
        tick();
        bus.mem_valid = 1'b0;
        bus.mem_data  = 16'($urandom);
        bus.done_in   = 1'b0;
        if (op == 4'b0000) begin
            exp_count = exp_count + 16'd1;
            chk("nop_pulse", 16'(bus.pc_inc_nop), 16'h1);
            chk("nop_ir", bus.fullBitNum, 16'h0000);
            chk("nop_count", bus.instr_count, exp_count);
            tick();
            chk("nop_pulse_end", 16'(bus.pc_inc_nop), 16'h0);
            chk("nop_bubble_ir", bus.fullBitNum, 16'h0000);
            chk("nop_bubble_req", 16'(bus.mem_req), 16'h0);
            expect_refetch();
        end else if (op == HALT_OP) begin
            exp_count = exp_count + 16'd1;
            chk("halt_flag", 16'(bus.halted), 16'h1);
            chk("halt_ir", bus.fullBitNum, 16'h0000);
            chk("halt_count", bus.instr_count, exp_count);
            repeat (50) begin
                bus.done_in = 1'($urandom_range(0, 1));
                tick();
                if (bus.mem_req !== 1'b0 || bus.halted !== 1'b1 || bus.fullBitNum !== 16'h0000) bad++;
            end
            bus.done_in = 1'b0;
            chk("halt_hold", 16'(bad), 16'h0);
            chk("halt_count_hold", bus.instr_count, exp_count);
        end else begin
            retire = (done_delay <= TIMEOUT);
            len    = retire ? done_delay : TIMEOUT;
            for (int k = 1; k <= len; k++) begin
                if (bus.fullBitNum !== word || bus.mem_req !== 1'b0) bad++;
                bus.done_in = (k == done_delay);
                tick();
            end
            bus.done_in = 1'b0;
            chk("exec_ir_stable", 16'(bad), 16'h0);
            if (retire) exp_count = exp_count + 16'd1;
            else        exp_terr = 16'h1;
            chk("bubble_ir", bus.fullBitNum, 16'h0000);
            chk("bubble_req", 16'(bus.mem_req), 16'h0);
            chk("bubble_count", bus.instr_count, exp_count);
            chk("bubble_timeout", 16'(bus.timeout_err), exp_terr);
            expect_refetch();
        end
    endtask

    initial begin
        int bad;
        bus.run       = 1'b0;
        bus.step      = 1'b0;
        bus.mem_data  = 16'h0000;
        bus.mem_valid = 1'b0;
        bus.done_in   = 1'b0;
        exp_count     = 16'h0000;
        exp_terr      = 16'h0000;

        #2 rst = 1'b0;
        #1 chk_reset_vals("reset_async");
        tick();
        tick();
        chk_reset_vals("reset_held");
        rst = 1'b1;
        tick();
        chk("idle_no_req", 16'(bus.mem_req), 16'h0);
        bus.run = 1'b1;
        tick();
        chk("first_req", 16'(bus.mem_req), 16'h1);

        run_instr(16'h7083, 2, 0);
        chk("first_count", bus.instr_count, 16'h0002 - 16'h0001);
        run_instr(16'h0000, 1, 1);
        run_instr(16'h2ABC, TIMEOUT, 2);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 14));
            run_instr({op, 12'($urandom)}, $urandom_range(1, 6), $urandom_range(0, 3));
        end

        run_instr(16'h1234, 1000, 0);
        run_instr(16'h3456, 1, 1);
        run_instr(16'h0000, 1, 0);

        wait_req(200);
        bus.run = 1'b0;
        tick();
        chk("abort_pending_req", 16'(bus.mem_req), 16'h1);
        bus.mem_data  = 16'h7083;
        bus.mem_valid = 1'b1;
        tick();
        bus.mem_valid = 1'b0;
        chk("abort_req", 16'(bus.mem_req), 16'h0);
        chk("abort_ir", bus.fullBitNum, 16'h0000);
        bad = 0;
        repeat (5) begin
            tick();
            if (bus.mem_req !== 1'b0 || bus.fullBitNum !== 16'h0000) bad++;
        end
        chk("abort_idle", 16'(bad), 16'h0);
        chk("abort_count", bus.instr_count, exp_count);
        bus.run = 1'b1;
        tick();
        chk("resume_req", 16'(bus.mem_req), 16'h1);

        for (int i = 0; i < 8; i++) begin
            run_instr({4'($urandom_range(1, 14)), 12'($urandom)}, $urandom_range(1, 4), $urandom_range(0, 2));
        end

        wait_req(200);
        bus.mem_data  = 16'h7083;
        bus.mem_valid = 1'b1;
        tick();
        bus.mem_valid = 1'b0;
        chk("midexec_ir1", bus.fullBitNum, 16'h7083);
        tick();
        chk("midexec_ir2", bus.fullBitNum, 16'h7083);
        #2 rst = 1'b0;
        #1 chk_reset_vals("midexec_reset");
        exp_count = 16'h0000;
        exp_terr  = 16'h0000;
        tick();
        tick();
        rst = 1'b1;

        run_instr(16'h5A5A, 3, 1);
        run_instr(16'hF000, 1, 0);
        rst = 1'b0;
        #1 chk_reset_vals("halt_reset");
        exp_count = 16'h0000;
        tick();
        rst = 1'b1;
        run_instr(16'h6001, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
